// File: rtl/arbitro_round_robin.sv
// arbitro_round_robin: four-requester round-robin arbiter for one shared
// datapath resource. The owner keeps its one-hot grant until it pulses done
// or drops its request. Every grant is followed by one dead (GAP) cycle, and
// the search for the next owner starts just after the previous owner.
//
// Optional feature, macro ARB_TIMEOUT_EN: adds a hold counter that forcibly
// revokes a grant after MAX_HOLD cycles and pulses timeout during the GAP
// that follows. Without the macro a grant has no upper bound and timeout
// is tied low.
//
// All outputs decode from registered state only; req/done never reach an
// output combinationally.
module arbitro_round_robin #(
    parameter int MAX_HOLD = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        GRANT = 3'b010,
        GAP   = 3'b100
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic       hit;
    logic [1:0] hit_idx;
    logic       rel;
    logic       force_rel;

    // The owner gives the resource back when it finishes or loses interest.
    assign rel = done || !req[owner];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             to_flag;

    // Forced release only when the owner has not released on its own in the
    // same cycle, so a coinciding done is a normal release without timeout.
    assign force_rel = (hold_cnt == CNT_W'(MAX_HOLD - 1)) && !rel;
    assign timeout   = to_flag;
`else
    logic unused_cfg;

    assign force_rel  = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = ^{MAX_HOLD, CNT_W};
`endif

    // Round-robin search: first requester at or after ptr, wrapping 3 -> 0.
    always_comb begin
        logic [1:0] idx;
        hit     = 1'b0;
        hit_idx = ptr;
        idx     = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!hit && req[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    // State register; reset lands in IDLE even mid-grant, skipping GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; any illegal encoding recovers to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, GAP: state_nxt = hit ? GRANT : IDLE;
            GRANT:     state_nxt = (rel || force_rel) ? GAP : GRANT;
            default:   state_nxt = IDLE;
        endcase
    end

    // Owner, priority pointer and (optional) hold counter / timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= 2'd0;
            owner    <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
            to_flag  <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            to_flag <= 1'b0;
`endif
            case (state)
                IDLE, GAP: begin
                    if (hit) begin
                        owner    <= hit_idx;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt <= hold_cnt + CNT_W'(1);
`endif
                    if (rel || force_rel) begin
                        ptr     <= owner + 2'd1;
`ifdef ARB_TIMEOUT_EN
                        to_flag <= force_rel;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from state and owner registers only.
    always_comb begin
        gnt  = 4'b0000;
        busy = 1'b0;
        if (state == GRANT) begin
            gnt  = 4'b0001 << owner;
            busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_arbitro_round_robin.sv
// tb_arbitro_round_robin: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the arbiter.
module tb_arbitro_round_robin;

    localparam int MAX_HOLD = 10;
    localparam int CNT_W    = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] obs;
    logic [7:0] exp_v;

    // Behavioural model: who owns the resource, where the next search starts,
    // how many grant cycles the owner has used, and whether the last grant was
    // taken away by force.
    bit m_grant;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    arbitro_round_robin #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    assign obs = {gnt, owner, busy, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_outputs();
        logic [3:0] g;
        g = m_grant ? 4'(1 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), m_grant, m_to};
    endfunction

    function automatic logic [7:0] granted(input int idx);
        return {4'(1 << idx), 2'(idx), 1'b1, 1'b0};
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, settle after it.
    task automatic drive(input logic [3:0] rq, input logic dn, input logic rs);
        bit rel;
        bit forced;
        bit found;
        req  = rq;
        done = dn;
        rst  = rs;
        @(posedge clk);
        if (rs) begin
            m_grant = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (m_grant) begin
            m_held = m_held + 1;
            rel    = dn || !rq[m_owner];
            forced = 0;
`ifdef ARB_TIMEOUT_EN
            forced = !rel && (m_held >= MAX_HOLD);
`endif
            m_to = forced;
            if (rel || forced) begin
                m_grant = 0;
                m_ptr   = (m_owner + 1) % 4;
            end
        end else begin
            m_to  = 0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && rq[(m_ptr + k) % 4]) begin
                    found   = 1;
                    m_grant = 1;
                    m_owner = (m_ptr + k) % 4;
                    m_held  = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(4'b1111, 1'b0, 1'b1);
            vectors++;
            if (obs !== 8'b0000_00_0_0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold[%0d]: got {gnt,owner,busy,to}=%b want %b", i, obs, 8'b0000_00_0_0);
            end
        end
        drive(4'b1111, 1'b0, 1'b0);
        vectors++;
        if (obs !== granted(0)) begin
            miscompares++;
            $display("[TB] FAIL reset_first_grant: got %b want %b", obs, granted(0));
        end
    endtask

    task automatic test_single_requester();
        drive(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0100, 1'b0, 1'b0);
            vectors++;
            if (obs !== granted(2)) begin
                miscompares++;
                $display("[TB] FAIL single_grant[%0d]: got %b want %b", c, obs, granted(2));
            end
        end
        drive(4'b0100, 1'b1, 1'b0);
        vectors++;
        if (obs !== 8'b0000_10_0_0) begin
            miscompares++;
            $display("[TB] FAIL single_release: got %b want %b", obs, 8'b0000_10_0_0);
        end
        drive(4'b1111, 1'b0, 1'b0);
        vectors++;
        if (obs !== granted(3)) begin
            miscompares++;
            $display("[TB] FAIL single_next_is_3: got %b want %b", obs, granted(3));
        end
    endtask

    task automatic test_fairness();
        logic [7:0] gap_v;
        drive(4'b0000, 1'b0, 1'b1);
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 2; c++) begin
                drive(4'b1111, c == 1, 1'b0);
                exp_v = (c == 0) ? granted(g % 4) : granted(g % 4);
                if (c == 1) begin
                    gap_v = {4'b0000, 2'(g % 4), 1'b0, 1'b0};
                    exp_v = gap_v;
                end
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("[TB] FAIL fairness g%0d c%0d: got %b want %b", g, c, obs, exp_v);
                end
                if (c == 0) begin
                    drive(4'b1111, 1'b0, 1'b0);
                    vectors++;
                    if (obs !== granted(g % 4)) begin
                        miscompares++;
                        $display("[TB] FAIL fairness_hold g%0d: got %b want %b", g, obs, granted(g % 4));
                    end
                end
            end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] pat;
        for (int run = 0; run < 2; run++) begin
            pat = (run == 0) ? 4'b0010 : 4'b1010;
            drive(4'b0000, 1'b0, 1'b1);
            for (int c = 0; c < MAX_HOLD; c++) begin
                drive(pat, 1'b0, 1'b0);
                vectors++;
                if (obs !== granted(1)) begin
                    miscompares++;
                    $display("[TB] FAIL timeout_hold r%0d c%0d: got %b want %b", run, c, obs, granted(1));
                end
            end
            drive(pat, 1'b0, 1'b0);
            vectors++;
            if (obs !== 8'b0000_01_0_1) begin
                miscompares++;
                $display("[TB] FAIL timeout_pulse r%0d: got %b want %b", run, obs, 8'b0000_01_0_1);
            end
            drive(pat, 1'b0, 1'b0);
            exp_v = (run == 0) ? granted(1) : granted(3);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL timeout_regrant r%0d: got %b want %b", run, obs, exp_v);
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        drive(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 60; c++) begin
            drive(4'b0010, 1'b0, 1'b0);
            vectors++;
            if (obs !== granted(1)) begin
                miscompares++;
                $display("[TB] FAIL unbounded_hold c%0d: got %b want %b", c, obs, granted(1));
            end
        end
    endtask
`endif

    task automatic test_reset_mid_grant();
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0100, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        vectors++;
        if (obs !== granted(2)) begin
            miscompares++;
            $display("[TB] FAIL midrst_owner2: got %b want %b", obs, granted(2));
        end
        drive(4'b1001, 1'b0, 1'b1);
        vectors++;
        if (obs !== 8'b0000_00_0_0) begin
            miscompares++;
            $display("[TB] FAIL midrst_cleared: got %b want %b", obs, 8'b0000_00_0_0);
        end
        drive(4'b1001, 1'b0, 1'b0);
        vectors++;
        if (obs !== granted(0)) begin
            miscompares++;
            $display("[TB] FAIL midrst_grant0: got %b want %b", obs, granted(0));
        end
        drive(4'b1001, 1'b1, 1'b0);
        vectors++;
        if (obs !== 8'b0000_00_0_0) begin
            miscompares++;
            $display("[TB] FAIL midrst_gap: got %b want %b", obs, 8'b0000_00_0_0);
        end
        drive(4'b1001, 1'b0, 1'b0);
        vectors++;
        if (obs !== granted(3)) begin
            miscompares++;
            $display("[TB] FAIL midrst_grant3: got %b want %b", obs, granted(3));
        end
    endtask

    task automatic test_random_traffic();
        logic [3:0] rq;
        logic       dn;
        logic       rs;
        rq = 4'($urandom);
        drive(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) rq = 4'($urandom);
            dn = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 149) == 0);
            drive(rq, dn, rs);
            exp_v = model_outputs();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL random c%0d req=%b done=%b rst=%b: got %b want %b", c, rq, dn, rs, obs, exp_v);
            end
        end
    endtask

    initial begin
        req  = 4'b0000;
        done = 1'b0;
        rst  = 1'b1;
        m_grant = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        test_reset();
        test_single_requester();
        test_fairness();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_grant();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
